// File: rtl/main_memory.sv
// Word-addressed storage with a fixed-latency request handshake and a clear-on-reset sweep.
// Optional feature macro: MEM_RANGE_CHECK_EN adds mem_err for out-of-range or misaligned requests.
module main_memory #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mem_rdy,
    output logic                  mem_valid
`ifdef MEM_RANGE_CHECK_EN
   ,output logic                  mem_err
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {INIT, IDLE, BUSY, DONE} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       init_idx_q;
    logic [IDX_W-1:0]       addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  din_q;
    logic                   wr_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]       req_idx_c;
    logic                   range_err_c;
    logic                   mem_we_c;
    logic [IDX_W-1:0]       mem_wa_c;
    logic [DATA_WIDTH-1:0]  mem_wd_c;

    assign req_idx_c = mem_addr[IDX_W+1:2];

`ifdef MEM_RANGE_CHECK_EN
    assign range_err_c = (mem_addr >= ADDR_WIDTH'(DEPTH_WORDS * 4)) || (mem_addr[1:0] != 2'b00);
`else
    // High bits alias and byte offset is ignored when range checking is off.
    logic unused_addr_c;
    assign range_err_c   = 1'b0;
    assign unused_addr_c = ^{mem_addr[ADDR_WIDTH-1:IDX_W+2], mem_addr[1:0]};
`endif

    // Single storage write port: init sweep or committed write, never while in reset.
    always_comb begin
        mem_we_c = 1'b0;
        mem_wa_c = init_idx_q;
        mem_wd_c = '0;
        if (!rst) begin
            if (state_q == INIT) begin
                mem_we_c = 1'b1;
            end else if (state_q == DONE && wr_q && !err_q) begin
                mem_we_c = 1'b1;
                mem_wa_c = addr_q;
                mem_wd_c = din_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_wa_c] <= mem_wd_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            mem_rdy    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_dout   <= '0;
`ifdef MEM_RANGE_CHECK_EN
            mem_err    <= 1'b0;
`endif
        end else begin
            mem_valid <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            mem_err   <= 1'b0;
`endif
            case (state_q)
                INIT: begin
                    if (init_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                        state_q <= IDLE;
                        mem_rdy <= 1'b1;
                    end else begin
                        init_idx_q <= init_idx_q + IDX_W'(1);
                    end
                end
                IDLE: begin
                    // Simultaneous read and write requests collapse to a write.
                    if (mem_ren || mem_wen) begin
                        addr_q  <= req_idx_c;
                        din_q   <= mem_din;
                        wr_q    <= mem_wen;
                        err_q   <= range_err_c;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        mem_rdy <= 1'b0;
                        state_q <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    mem_valid <= 1'b1;
                    mem_rdy   <= 1'b1;
                    state_q   <= IDLE;
`ifdef MEM_RANGE_CHECK_EN
                    mem_err   <= err_q;
`endif
                    if (!wr_q) begin
                        mem_dout <= err_q ? '0 : mem_q[addr_q];
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule
